reg_pipe_en: RTL and testbench

Parametrised pipeline register chain: a DEPTH-stage, WIDTH-bit delay line built from resettable, enable-gated D flip-flops.

- Each stage carries a data word and a valid bit.
- A global enable stalls the whole chain, and a flush clears all valid bits.
- A registered occupancy counter reports how many stages currently hold valid data.
- It is the general successor to the single-bit reset/enable D flip-flop, used wherever a datapath needs a fixed, stallable latency.

---
 rtl/reg_pipe_en.sv | 54 +++++
 tb/tb_reg_pipe_en.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_pipe_en.sv
// Stallable, flushable DEPTH-stage delay line for WIDTH-bit data with per-stage valid bits.
// Outputs come straight from the last stage; occupancy is a registered count of valid stages.
`timescale 1ns/1ps

module reg_pipe_en #(
    parameter int              WIDTH       = 8,
    parameter int              DEPTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           d,
    output logic [WIDTH-1:0]           q,
    output logic                       out_valid,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] stage [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [OCC_W-1:0] occ;

    // Flush drops valids only; stage data is left in place.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage[i] <= RESET_VALUE;
            end
            valid <= '0;
            occ   <= '0;
        end else if (flush) begin
            valid <= '0;
            occ   <= '0;
        end else if (en) begin
            stage[0] <= d;
            valid[0] <= in_valid;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
                valid[i] <= valid[i-1];
            end
            // Entry and exit in the same cycle cancel out.
            occ <= occ + OCC_W'(in_valid) - OCC_W'(valid[DEPTH-1]);
        end
    end

    assign q         = stage[DEPTH-1];
    assign out_valid = valid[DEPTH-1];
    assign occupancy = occ;

endmodule

// File: tb/tb_reg_pipe_en.sv
// Directed bench for reg_pipe_en (DEPTH 4 and DEPTH 1 side by side, shared inputs).
// Expected words are queued at issue; a monitor pops them as outputs advance.
`timescale 1ns/1ps

module tb_reg_pipe_en;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] d = 8'h00;

    logic [7:0] q4, q1;
    logic       ov4, ov1;
    logic [2:0] occ4;
    logic [0:0] occ1;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    logic        adv_q = 1'b0;

    typedef struct {
        logic [7:0]  data;
        int unsigned due;
    } exp_t;

    exp_t sb4[$];
    exp_t sb1[$];
    exp_t x4, x1;

    reg_pipe_en #(.WIDTH(8), .DEPTH(4), .RESET_VALUE(8'hA5)) dut4 (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(in_valid),
        .d(d), .q(q4), .out_valid(ov4), .occupancy(occ4)
    );

    reg_pipe_en #(.WIDTH(8), .DEPTH(1), .RESET_VALUE(8'hA5)) dut1 (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(in_valid),
        .d(d), .q(q1), .out_valid(ov1), .occupancy(occ1)
    );

    always #10 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        adv_q <= en && !flush && !reset;
    end

    // A word is presented on the cycle after an advancing edge that leaves out_valid high.
    always @(negedge clk) begin
        if (adv_q) begin
            if (ov4) begin
                checks++;
                if (sb4.size() == 0) begin
                    errors++;
                    $display("FAIL d4_out: got q=%h at edge %0d, expected no valid output", q4, cyc);
                end else begin
                    x4 = sb4.pop_front();
                    if (x4.data !== q4 || x4.due != cyc) begin
                        errors++;
                        $display("FAIL d4_out: got q=%h at edge %0d, expected %h at edge %0d",
                                 q4, cyc, x4.data, x4.due);
                    end
                end
            end else if (sb4.size() != 0 && sb4[0].due == cyc) begin
                checks++;
                errors++;
                $display("FAIL d4_missing: got out_valid=0 at edge %0d, expected %h", cyc, sb4[0].data);
            end
            if (ov1) begin
                checks++;
                if (sb1.size() == 0) begin
                    errors++;
                    $display("FAIL d1_out: got q=%h at edge %0d, expected no valid output", q1, cyc);
                end else begin
                    x1 = sb1.pop_front();
                    if (x1.data !== q1 || x1.due != cyc) begin
                        errors++;
                        $display("FAIL d1_out: got q=%h at edge %0d, expected %h at edge %0d",
                                 q1, cyc, x1.data, x1.due);
                    end
                end
            end else if (sb1.size() != 0 && sb1[0].due == cyc) begin
                checks++;
                errors++;
                $display("FAIL d1_missing: got out_valid=0 at edge %0d, expected %h", cyc, sb1[0].data);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one edge; lat4 is the edge offset at which a DEPTH-4 word should emerge.
    task automatic go(input logic r, input logic e, input logic f, input logic iv,
                      input logic [7:0] dv, input int unsigned lat4);
        @(negedge clk);
        reset    = r;
        en       = e;
        flush    = f;
        in_valid = iv;
        d        = dv;
        @(posedge clk);
        #1;
        if (!r && !f && e && iv) begin
            sb4.push_back('{dv, cyc + lat4});
            sb1.push_back('{dv, cyc});
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] eq4, input logic eov4,
                           input logic [2:0] eocc4, input logic [7:0] eq1, input logic eov1);
        chk({tag, "_q4"}, q4, eq4);
        chk({tag, "_ov4"}, ov4, eov4);
        chk({tag, "_occ4"}, occ4, eocc4);
        chk({tag, "_q1"}, q1, eq1);
        chk({tag, "_ov1"}, ov1, eov1);
        chk({tag, "_occ1"}, occ1, eov1);
    endtask

    initial begin
        int unsigned lat_occ[5] = '{1, 2, 3, 4, 4};
        int unsigned bub_occ[4] = '{1, 1, 2, 2};
        int unsigned drn_occ[3] = '{1, 1, 0};
        logic        drn_ov[3]  = '{1'b0, 1'b1, 1'b0};

        // reset with active-looking inputs
        for (int i = 0; i < 2; i++) begin
            go(1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, 3);
            chk_all("reset", 8'hA5, 1'b0, 3'd0, 8'hA5, 1'b0);
        end

        // latency 01..05
        for (int i = 0; i < 5; i++) begin
            go(1'b0, 1'b1, 1'b0, 1'b1, 8'(i + 1), 3);
            chk("lat_occ4", occ4, lat_occ[i]);
            chk("lat_occ1", occ1, 1);
        end

        // stall: 10 emerges on the fourth issue, 11..13 are delayed by three stalls
        go(1'b0, 1'b1, 1'b0, 1'b1, 8'h10, 3);
        go(1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 6);
        go(1'b0, 1'b1, 1'b0, 1'b1, 8'h12, 6);
        go(1'b0, 1'b1, 1'b0, 1'b1, 8'h13, 6);
        for (int i = 0; i < 3; i++) begin
            go(1'b0, 1'b0, 1'b0, 1'b1, 8'hEE, 3);
            chk_all("stall", 8'h10, 1'b1, 3'd4, 8'h13, 1'b1);
        end
        for (int i = 0; i < 3; i++) begin
            go(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3);
            chk("resume_occ4", occ4, 3 - i);
            chk("resume_ov1", ov1, 1'b0);
        end

        // bubbles 1,0,1,0 then drain
        for (int i = 0; i < 4; i++) begin
            go(1'b0, 1'b1, 1'b0, (i % 2 == 0), 8'(8'h21 + i), 3);
            chk("bub_occ4", occ4, bub_occ[i]);
            chk("bub_occ1", occ1, (i % 2 == 0));
        end
        chk("bub_ov4_0", ov4, 1'b1);
        for (int i = 0; i < 3; i++) begin
            go(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3);
            chk("drain_occ4", occ4, drn_occ[i]);
            chk("drain_ov4", ov4, drn_ov[i]);
        end

        // flush precedence over en with three valid stages
        go(1'b0, 1'b1, 1'b0, 1'b1, 8'h31, 3);
        go(1'b0, 1'b1, 1'b0, 1'b1, 8'h32, 3);
        go(1'b0, 1'b1, 1'b0, 1'b1, 8'h33, 3);
        chk("pre_flush_occ4", occ4, 3);
        go(1'b0, 1'b1, 1'b1, 1'b1, 8'h77, 3);
        sb4.delete();
        sb1.delete();
        chk_all("flush", 8'h00, 1'b0, 3'd0, 8'h33, 1'b0);
        for (int i = 0; i < 4; i++) begin
            go(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3);
            chk("post_flush_ov4", ov4, 1'b0);
            chk("post_flush_occ4", occ4, 0);
        end

        // flush while stalled
        go(1'b0, 1'b1, 1'b0, 1'b1, 8'h41, 3);
        chk("pre_sflush_occ4", occ4, 1);
        go(1'b0, 1'b0, 1'b1, 1'b1, 8'h55, 3);
        sb4.delete();
        sb1.delete();
        chk_all("stall_flush", 8'h00, 1'b0, 3'd0, 8'h41, 1'b0);

        // reset wins over flush
        go(1'b0, 1'b1, 1'b0, 1'b1, 8'h51, 3);
        go(1'b1, 1'b1, 1'b1, 1'b1, 8'h66, 3);
        sb4.delete();
        sb1.delete();
        chk_all("reset_flush", 8'hA5, 1'b0, 3'd0, 8'hA5, 1'b0);
        go(1'b0, 1'b0, 1'b0, 1'b1, 8'h99, 3);
        chk_all("post_reset_hold", 8'hA5, 1'b0, 3'd0, 8'hA5, 1'b0);

        // latency rerun, DEPTH 1 follows d one edge later
        for (int i = 0; i < 5; i++) begin
            go(1'b0, 1'b1, 1'b0, 1'b1, 8'(8'h61 + i), 3);
            chk("rerun_q1", q1, 8'(8'h61 + i));
            chk("rerun_occ1", occ1, 1);
        end
        for (int i = 0; i < 4; i++) begin
            go(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3);
        end
        @(negedge clk);
        chk("sb4_drained", sb4.size(), 0);
        chk("sb1_drained", sb1.size(), 0);
        chk("final_occ4", occ4, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200us;
        $display("FAIL watchdog: got no completion, expected finish before 200us");
        $fatal(1);
    end

endmodule
